dm_resp: RTL and testbench

- Multi-cycle data-memory responder; the memory-side end of the core's load/store interface.
- Replaces the zero-wait dm_4k when the pipelined/multi-cycle core needs a req/ready handshake.
- Accepts one word-aligned read or byte-enabled write at a time.
- Inserts a fixed, parameterised number of wait cycles, then pulses ready; read data is valid during the ready cycle.

---
 rtl/dm_resp_if.sv | 16 +
 rtl/dm_resp.sv | 94 +++++++++
 tb/tb_dm_resp.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_resp_if.sv
// Load/store handshake between the core (master) and the multi-cycle data memory (slave).
interface dm_resp_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ready;
    logic [31:0]       rdata;
    logic              busy;

    modport master (output req, we, addr, be, wdata, input ready, rdata, busy);
    modport slave  (input req, we, addr, be, wdata, output ready, rdata, busy);
endinterface

// File: rtl/dm_resp.sv
// Multi-cycle data-memory responder: accepts one read or byte-enabled write,
// waits LATENCY cycles, then pulses ready for one cycle with read data.
module dm_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic      clk,
    input logic      rst,
    dm_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // With LATENCY=0 this wraps to 4'hF, but WAIT is never entered in that case.
    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [3:0]        lat_be;
    logic [31:0]       lat_wdata;
    logic [31:0]       mem [0:(2**ADDR_W)-1];

    logic              enter_resp;
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        cur_be;
    logic [31:0]       cur_wdata;

    // The zero-latency path commits straight from the live inputs on the acceptance edge.
    always_comb begin
        enter_resp = 1'b0;
        cur_we     = lat_we;
        cur_addr   = lat_addr;
        cur_be     = lat_be;
        cur_wdata  = lat_wdata;
        if (state == IDLE) begin
            cur_we     = bus.we;
            cur_addr   = bus.addr;
            cur_be     = bus.be;
            cur_wdata  = bus.wdata;
            enter_resp = bus.req && (LATENCY == 0);
        end else if (state == WAIT) begin
            enter_resp = (cnt == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            bus.ready <= 1'b0;
            bus.rdata <= 32'd0;
            bus.busy  <= 1'b0;
        end else begin
            bus.ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        lat_we    <= bus.we;
                        lat_addr  <= bus.addr;
                        lat_be    <= bus.be;
                        lat_wdata <= bus.wdata;
                        cnt       <= 4'd0;
                        bus.busy  <= 1'b1;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 4'd1;
                    if (enter_resp) state <= RESP;
                end
                RESP: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                bus.ready <= 1'b1;
                if (!cur_we) bus.rdata <= mem[cur_addr];
            end
        end
    end

    // Storage survives reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_we) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: one LATENCY=2 and one LATENCY=0 instance,
// with a scoreboard of expected responses popped on each ready pulse.
module tb_dm_resp;
    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_resp_if #(.ADDR_W(10)) b2 ();
    dm_resp_if #(.ADDR_W(10)) b0 ();

    dm_resp #(.ADDR_W(10), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));
    dm_resp #(.ADDR_W(10), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    typedef struct {
        logic [31:0] rdata;
        int          accept;
    } exp_t;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    exp_t sb2[$];
    exp_t sb0[$];
    vec_t vecs[13];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic apply_stimulus(input bit sel0, input logic r, input logic w, input logic [9:0] a,
                                  input logic [3:0] b, input logic [31:0] d);
        if (sel0) begin
            b0.req = r; b0.we = w; b0.addr = a; b0.be = b; b0.wdata = d;
        end else begin
            b2.req = r; b2.we = w; b2.addr = a; b2.be = b; b2.wdata = d;
        end
    endtask

    task automatic wait_drain(input bit sel0);
        int n = 0;
        while (((sel0 ? sb0.size() : sb2.size()) != 0) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if ((sel0 ? sb0.size() : sb2.size()) != 0) begin
            checks++;
            $display("[TB] FAIL %s response timeout: got %0d pending, expected 0",
                     sel0 ? "dut0" : "dut2", sel0 ? sb0.size() : sb2.size());
            if (sel0) sb0.delete(); else sb2.delete();
        end
    endtask

    task automatic run_txn(input bit sel0, input logic w, input logic [9:0] a, input logic [3:0] b,
                           input logic [31:0] d, input logic [31:0] exp_rd);
        exp_t e;
        @(negedge clk);
        apply_stimulus(sel0, 1'b1, w, a, b, d);
        e.rdata  = exp_rd;
        e.accept = cyc + 1;
        if (sel0) sb0.push_back(e); else sb2.push_back(e);
        @(negedge clk);
        apply_stimulus(sel0, 1'b0, 1'b0, a, 4'h0, 32'h0);
        wait_drain(sel0);
    endtask

    // Response monitors: every ready pulse must match the oldest expected entry.
    always @(negedge clk) begin
        exp_t e2;
        if (b2.ready === 1'b1) begin
            if (sb2.size() == 0) begin
                checks++;
                $display("[TB] FAIL dut2 unexpected ready at cycle %0d: got 1, expected 0", cyc);
            end else begin
                e2 = sb2.pop_front();
                check_output("dut2 rdata", b2.rdata, e2.rdata);
                check_output("dut2 latency", 32'(cyc - e2.accept), 32'd2);
                check_output("dut2 busy in resp", 32'(b2.busy), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e0;
        if (b0.ready === 1'b1) begin
            if (sb0.size() == 0) begin
                checks++;
                $display("[TB] FAIL dut0 unexpected ready at cycle %0d: got 1, expected 0", cyc);
            end else begin
                e0 = sb0.pop_front();
                check_output("dut0 rdata", b0.rdata, e0.rdata);
                check_output("dut0 latency", 32'(cyc - e0.accept), 32'd0);
                check_output("dut0 busy in resp", 32'(b0.busy), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        vecs[0]  = '{1'b1, 10'h004, 4'hF, 32'hDEADBEEF, 32'h00000000};
        vecs[1]  = '{1'b0, 10'h004, 4'h0, 32'h00000000, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 10'h008, 4'hF, 32'h01234567, 32'hDEADBEEF};
        vecs[3]  = '{1'b1, 10'h010, 4'hF, 32'h11223344, 32'hDEADBEEF};
        vecs[4]  = '{1'b1, 10'h010, 4'h5, 32'hAABBCCDD, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 10'h010, 4'h0, 32'h00000000, 32'h11BB33DD};
        vecs[6]  = '{1'b1, 10'h010, 4'h0, 32'hFFFFFFFF, 32'h11BB33DD};
        vecs[7]  = '{1'b0, 10'h010, 4'h0, 32'h00000000, 32'h11BB33DD};
        vecs[8]  = '{1'b1, 10'h020, 4'hF, 32'h0BADF00D, 32'h11BB33DD};
        vecs[9]  = '{1'b1, 10'h3FF, 4'hF, 32'h5A5AA5A5, 32'h11BB33DD};
        vecs[10] = '{1'b0, 10'h3FF, 4'h0, 32'h00000000, 32'h5A5AA5A5};
        vecs[11] = '{1'b0, 10'h020, 4'h0, 32'h00000000, 32'h0BADF00D};
        vecs[12] = '{1'b0, 10'h008, 4'h0, 32'h00000000, 32'h01234567};

        // Reset held for two edges with a request pending.
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b1, 10'h030, 4'hF, 32'h12345678);
        apply_stimulus(1'b1, 1'b1, 1'b1, 10'h030, 4'hF, 32'h12345678);
        repeat (2) begin
            @(negedge clk);
            check_output("reset dut2 ready", 32'(b2.ready), 32'd0);
            check_output("reset dut2 busy", 32'(b2.busy), 32'd0);
            check_output("reset dut2 rdata", b2.rdata, 32'd0);
            check_output("reset dut0 ready", 32'(b0.ready), 32'd0);
            check_output("reset dut0 busy", 32'(b0.busy), 32'd0);
            check_output("reset dut0 rdata", b0.rdata, 32'd0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post-reset dut2 busy", 32'(b2.busy), 32'd0);
        check_output("post-reset dut0 busy", 32'(b0.busy), 32'd0);

        for (int i = 0; i < 13; i++)
            run_txn(1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].rdata);

        // Inputs change during WAIT of a read; latched request must win.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h004, 4'h0, 32'h0);
        e.rdata = 32'hDEADBEEF; e.accept = cyc + 1; sb2.push_back(e);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b1, 10'h008, 4'hF, 32'hFFFF0000);
        @(negedge clk);
        check_output("holdoff busy in wait", 32'(b2.busy), 32'd1);
        apply_stimulus(1'b0, 1'b0, 1'b1, 10'h008, 4'hF, 32'h0000FFFF);
        wait_drain(1'b0);
        run_txn(1'b0, 1'b0, 10'h008, 4'h0, 32'h0, 32'h01234567);
        @(negedge clk);
        check_output("idle dut2 busy", 32'(b2.busy), 32'd0);

        // req held high: acceptances every LATENCY+2 = 4 cycles.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            e.rdata = 32'h11BB33DD; e.accept = cyc + 1 + 4 * k; sb2.push_back(e);
        end
        repeat (9) @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        wait_drain(1'b0);

        // Zero-latency instance: live-input commit path and 2-cycle back-to-back.
        run_txn(1'b1, 1'b1, 10'h004, 4'hF, 32'hDEADBEEF, 32'h00000000);
        run_txn(1'b1, 1'b0, 10'h004, 4'h0, 32'h0, 32'hDEADBEEF);
        run_txn(1'b1, 1'b1, 10'h004, 4'h8, 32'h77000000, 32'hDEADBEEF);
        run_txn(1'b1, 1'b0, 10'h004, 4'h0, 32'h0, 32'h77ADBEEF);
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 1'b0, 10'h004, 4'h0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            e.rdata = 32'h77ADBEEF; e.accept = cyc + 1 + 2 * k; sb0.push_back(e);
        end
        repeat (5) @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        wait_drain(1'b1);

        // Reset on the edge that would enter RESP for a write.
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 1'b1, 10'h020, 4'hF, 32'hCAFEF00D);
        @(negedge clk);
        apply_stimulus(1'b0, 1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("midreset ready", 32'(b2.ready), 32'd0);
        check_output("midreset busy", 32'(b2.busy), 32'd0);
        check_output("midreset rdata", b2.rdata, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_output("after midreset busy", 32'(b2.busy), 32'd0);
        run_txn(1'b0, 1'b0, 10'h020, 4'h0, 32'h0, 32'h0BADF00D);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
